// File: rtl/rewire_ctx_sched.sv
// rewire_ctx_sched
// Time-multiplexes one combinational resumption core between NCTX requester
// contexts. Each context's saved core state and halted flag live here. Each
// cycle, at most one context is granted round-robin and advanced by exactly one
// core step. The step's output is returned on a registered response channel.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   req_valid[NCTX]     per-context step request
//   req_in[NCTX*IW]     per-context step input, context i at [i*IW +: IW]
//   req_ready[NCTX]     one-hot grant (combinational)
//   ctx_clear[NCTX]     per-context restart pulse (state <- RESET_STATE)
//   rsp_valid/ready     response handshake
//   rsp_ctx/out/halted  response payload: context, core output, halted flag
//   core_state/core_in  operands presented to the external core
//   core_next_state, core_out, core_cont   combinational core results
module rewire_ctx_sched #(
    parameter int NCTX = 4,
    parameter int STW  = 5,
    parameter int IW   = 1,
    parameter int OW   = 1,
    parameter logic [STW-1:0] RESET_STATE = 'h09,
    localparam int CW  = $clog2(NCTX)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCTX-1:0]      req_valid,
    input  logic [NCTX*IW-1:0]   req_in,
    output logic [NCTX-1:0]      req_ready,
    input  logic [NCTX-1:0]      ctx_clear,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [CW-1:0]        rsp_ctx,
    output logic [OW-1:0]        rsp_out,
    output logic                 rsp_halted,
    output logic [STW-1:0]       core_state,
    output logic [IW-1:0]        core_in,
    input  logic [STW-1:0]       core_next_state,
    input  logic [OW-1:0]        core_out,
    input  logic                 core_cont
);

    logic [STW-1:0] state_q [NCTX];
    logic [STW-1:0] state_d [NCTX];
    logic [NCTX-1:0] halted_q, halted_d;
    logic [CW-1:0]  ptr_q, ptr_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [CW-1:0]  rsp_ctx_q, rsp_ctx_d;
    logic [OW-1:0]  rsp_out_q, rsp_out_d;
    logic           rsp_halted_q, rsp_halted_d;

    logic            issue;
    logic            grant_valid;
    logic [CW-1:0]   grant_idx;
    logic [CW:0]     scan;
    logic            grant_halted;
    logic [NCTX-1:0] eligible;
    logic [NCTX-1:0] step_live;

    genvar gi;
    generate
        for (gi = 0; gi < NCTX; gi++) begin : g_ctx
            // A context being cleared cannot be granted, so clear and step never collide.
            assign eligible[gi]  = req_valid[gi] && !ctx_clear[gi];
            assign req_ready[gi] = grant_valid && (grant_idx == CW'(gi));
            // Only a non-halted context actually takes the core's result.
            assign step_live[gi] = req_ready[gi] && !halted_q[gi];
        end
    endgenerate

    // Round-robin scan starting at ptr. The index is kept one bit wider so the
    // wrap is a compare-and-subtract, which is correct for any NCTX.
    always_comb begin
        issue       = !rst && (!rsp_valid_q || rsp_ready);
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan        = '0;
        for (int k = 0; k < NCTX; k++) begin
            scan = {1'b0, ptr_q} + (CW+1)'(k);
            if (scan >= (CW+1)'(NCTX)) begin
                scan = scan - (CW+1)'(NCTX);
            end
            if (issue && !grant_valid && eligible[scan[CW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = scan[CW-1:0];
            end
        end
    end

    always_comb begin
        core_state   = '0;
        core_in      = '0;
        grant_halted = 1'b0;
        if (grant_valid) begin
            core_state   = state_q[grant_idx];
            core_in      = req_in[int'(grant_idx)*IW +: IW];
            grant_halted = halted_q[grant_idx];
        end
    end

    always_comb begin
        for (int i = 0; i < NCTX; i++) begin
            state_d[i]  = state_q[i];
            halted_d[i] = halted_q[i];
            if (ctx_clear[i]) begin
                state_d[i]  = RESET_STATE;
                halted_d[i] = 1'b0;
            end else if (step_live[i]) begin
                state_d[i]  = core_next_state;
                halted_d[i] = !core_cont;
            end
        end

        ptr_d = ptr_q;
        if (grant_valid) begin
            ptr_d = (grant_idx == CW'(NCTX-1)) ? '0 : grant_idx + 1'b1;
        end

        // Payload only reloads on acceptance, so it stays stable while stalled.
        rsp_valid_d  = rsp_valid_q;
        rsp_ctx_d    = rsp_ctx_q;
        rsp_out_d    = rsp_out_q;
        rsp_halted_d = rsp_halted_q;
        if (grant_valid) begin
            rsp_valid_d  = 1'b1;
            rsp_ctx_d    = grant_idx;
            rsp_out_d    = grant_halted ? '0 : core_out;
            rsp_halted_d = grant_halted ? 1'b1 : !core_cont;
        end else if (rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCTX; i++) begin
                state_q[i] <= RESET_STATE;
            end
            halted_q     <= '0;
            ptr_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_ctx_q    <= '0;
            rsp_out_q    <= '0;
            rsp_halted_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCTX; i++) begin
                state_q[i] <= state_d[i];
            end
            halted_q     <= halted_d;
            ptr_q        <= ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_ctx_q    <= rsp_ctx_d;
            rsp_out_q    <= rsp_out_d;
            rsp_halted_q <= rsp_halted_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_ctx    = rsp_ctx_q;
    assign rsp_out    = rsp_out_q;
    assign rsp_halted = rsp_halted_q;

endmodule

// File: tb/tb_rewire_ctx_sched.sv
// Self-checking bench for rewire_ctx_sched (NCTX=4, STW=5, IW=1, OW=1).
// The attached core is a small combinational function. A reference model keeps
// per-context state in arrays and arbitrates with modulo arithmetic.
module tb_rewire_ctx_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_valid;
    logic [3:0] req_in;
    logic [3:0] req_ready;
    logic [3:0] ctx_clear;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_ctx;
    logic [0:0] rsp_out;
    logic       rsp_halted;
    logic [4:0] core_state;
    logic [0:0] core_in;
    logic [4:0] core_next_state;
    logic [0:0] core_out;
    logic       core_cont;
    logic       cont_drive;

    always #5 clk = ~clk;

    rewire_ctx_sched dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_in(req_in), .req_ready(req_ready),
        .ctx_clear(ctx_clear),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ctx(rsp_ctx),
        .rsp_out(rsp_out), .rsp_halted(rsp_halted),
        .core_state(core_state), .core_in(core_in),
        .core_next_state(core_next_state), .core_out(core_out),
        .core_cont(core_cont)
    );

    function automatic logic [4:0] f_next(input logic [4:0] s, input logic i);
        return s + (i ? 5'd2 : 5'd7);
    endfunction
    function automatic logic f_out(input logic [4:0] s, input logic i);
        return i ^ s[4];
    endfunction

    assign core_next_state = f_next(core_state, core_in[0]);
    assign core_out        = f_out(core_state, core_in[0]);
    assign core_cont       = cont_drive;

    // Reference model
    logic [4:0] m_state [4];
    logic [3:0] m_halt;
    int         m_ptr;
    logic       m_rv;
    logic [1:0] m_rc;
    logic       m_ro;
    logic       m_rh;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_state[i] = 5'h09;
        m_halt = '0; m_ptr = 0;
        m_rv = 1'b0; m_rc = '0; m_ro = 1'b0; m_rh = 1'b0;
    endtask

    // One cycle: entered at posedge+1, drives inputs, checks at the falling
    // edge, updates the model at the next rising edge, returns at posedge+1.
    task automatic step(input logic [3:0] v, input logic [3:0] clr, input logic rr,
                        input logic c, input logic [3:0] in_bits);
        int g;
        logic [4:0] nxt;
        logic o;
        req_valid = v; ctx_clear = clr; rsp_ready = rr; cont_drive = c; req_in = in_bits;
        #4;
        chk("rsp_valid", rsp_valid, m_rv);
        chk("rsp_ctx", rsp_ctx, m_rc);
        chk("rsp_out", rsp_out, m_ro);
        chk("rsp_halted", rsp_halted, m_rh);
        g = -1;
        if (!m_rv || rr) begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (m_ptr + k) % 4;
                if (g < 0 && v[idx] && !clr[idx]) g = idx;
            end
        end
        chk("req_ready", req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
        if (g >= 0) begin
            chk("core_state", core_state, m_state[g]);
            chk("core_in", core_in, in_bits[g]);
            nxt = f_next(m_state[g], in_bits[g]);
            o   = f_out(m_state[g], in_bits[g]);
        end else begin
            nxt = '0; o = 1'b0;
        end
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (clr[i]) begin m_state[i] = 5'h09; m_halt[i] = 1'b0; end
        end
        if (g >= 0) begin
            m_rv = 1'b1; m_rc = 2'(g);
            if (m_halt[g]) begin
                m_ro = 1'b0; m_rh = 1'b1;
            end else begin
                m_ro = o; m_rh = !c;
                m_state[g] = nxt; m_halt[g] = !c;
            end
            m_ptr = (g + 1) % 4;
        end else if (rr) begin
            m_rv = 1'b0;
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_valid = 4'hF; req_in = '0; ctx_clear = '0;
        rsp_ready = 1'b1; cont_drive = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #4;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_ctx", rsp_ctx, 0);
        chk("reset_rsp_out", rsp_out, 0);
        chk("reset_rsp_halted", rsp_halted, 0);
        chk("reset_req_ready", req_ready, 0);
        rst = 1'b0; req_valid = '0;
        @(posedge clk); #1;

        // Single step on ctx0, then a second ctx0 step sees 5'h0B
        step(4'b0001, 4'b0000, 1, 1, 4'b0001);
        step(4'b0000, 4'b0000, 1, 1, 4'b0000);
        chk("ctx0_state_after_step", m_state[0], 5'h0B);
        step(4'b0001, 4'b0000, 1, 1, 4'b0000);
        step(4'b0000, 4'b0000, 1, 1, 4'b0000);

        // Round-robin with all requesting, then alternating 1/3
        repeat (8) step(4'b1111, 4'b0000, 1, 1, 4'(($urandom)));
        repeat (4) step(4'b1010, 4'b0000, 1, 1, 4'(($urandom)));

        // Isolation: interleave ctx1 and ctx2
        for (int i = 0; i < 10; i++)
            step(($urandom_range(0, 1) != 0) ? 4'b0010 : 4'b0100, 4'b0000, 1, 1, 4'(($urandom)));

        // Halt on ctx2, re-request halted ctx2, clear, restart
        step(4'b0100, 4'b0000, 1, 0, 4'b0100);
        step(4'b0100, 4'b0000, 1, 1, 4'b0100);
        step(4'b0000, 4'b0100, 1, 1, 4'b0000);
        step(4'b0100, 4'b0000, 1, 1, 4'b0000);
        step(4'b0000, 4'b0000, 1, 1, 4'b0000);

        // Backpressure: pending response held for 3 cycles, then released
        step(4'b0001, 4'b0000, 0, 1, 4'b0001);
        repeat (3) step(4'b1111, 4'b0000, 0, 1, 4'b1111);
        step(4'b1111, 4'b0000, 1, 1, 4'b0000);

        // Drive ptr to 0 via a ctx3 grant, then clear/request collision on ctx0
        step(4'b1000, 4'b0000, 1, 1, 4'b0000);
        step(4'b0011, 4'b0001, 1, 1, 4'b0011);
        step(4'b0001, 4'b0000, 1, 1, 4'b0000);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [3:0] clr;
            clr = '0;
            for (int j = 0; j < 4; j++) clr[j] = ($urandom_range(0, 7) == 0);
            step(4'(($urandom)), clr, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) != 0), 4'(($urandom)));
        end

        // Asynchronous reset with a pending, stalled response
        step(4'b0100, 4'b0000, 0, 1, 4'b0100);
        req_valid = 4'b1111; rsp_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("async_rst_rsp_valid", rsp_valid, 0);
        chk("async_rst_req_ready", req_ready, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        step(4'b0100, 4'b0000, 1, 1, 4'b0000);
        step(4'b0010, 4'b0000, 1, 1, 4'b0000);
        step(4'b0000, 4'b0000, 1, 1, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
